// File: rtl/ex_shift_alu_unit.sv
// Execute-stage ALU plus serial shifter with a valid/ready result handshake.
// Optional build macro EX_FLAGS_EN adds the registered zero_o/ovf_o result flags.
//
// state | meaning
// IDLE  | accepting ops; ALU results and zero-amount shifts load in one cycle
// SHIFT | serial shift in progress; upstream is stalled
module ex_shift_alu_unit #(
  parameter int DATA_W     = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [3:0]                alu_op_i,
  input  logic [1:0]                fu_sel_i,
  input  logic                      left_right_i,
  input  logic [DATA_W-1:0]         src_a_i,
  input  logic [DATA_W-1:0]         src_b_i,
  input  logic [$clog2(DATA_W)-1:0] shamt_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATA_W-1:0]         result_o
`ifdef EX_FLAGS_EN
  ,
  output logic                      zero_o,
  output logic                      ovf_o
`endif
);

  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int STEP_W  = $clog2(DATA_W + 1);
  localparam logic [STEP_W-1:0] STEP_V = STEP_W'(SHIFT_STEP);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
  logic [SHAMT_W-1:0]  cnt, cnt_n;
  logic                dir, dir_n;
  logic [DATA_W-1:0]   result_n;
  logic                out_valid_n;
  logic                accept;
  logic                can_load;
  logic                load;
  logic [DATA_W-1:0]   load_val;
  logic [SHAMT_W-1:0]  step_k;
  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   alu_res;
  logic [DATA_W-1:0]   sum;
  logic [DATA_W-1:0]   diff;
`ifdef EX_FLAGS_EN
  logic                alu_ovf;
  logic                load_ovf;
  logic                zero_n;
  logic                ovf_n;
`endif

  // A pending result may retire on the same edge a new one is loaded.
  assign can_load   = !out_valid_o || out_ready_i;
  assign in_ready_o = (state == IDLE) && can_load;
  assign accept     = in_valid_i && in_ready_o;

  assign sum  = src_a_i + src_b_i;
  assign diff = src_a_i - src_b_i;

  always_comb begin
    alu_res = '0;
`ifdef EX_FLAGS_EN
    alu_ovf = 1'b0;
`endif
    case (alu_op_i)
      4'b0010: begin
        alu_res = sum;
`ifdef EX_FLAGS_EN
        alu_ovf = (src_a_i[DATA_W-1] == src_b_i[DATA_W-1]) &&
                  (sum[DATA_W-1] != src_a_i[DATA_W-1]);
`endif
      end
      4'b0110: begin
        alu_res = diff;
`ifdef EX_FLAGS_EN
        alu_ovf = (src_a_i[DATA_W-1] != src_b_i[DATA_W-1]) &&
                  (diff[DATA_W-1] != src_a_i[DATA_W-1]);
`endif
      end
      4'b0000: alu_res = src_a_i & src_b_i;
      4'b0001: alu_res = src_a_i | src_b_i;
      4'b1100: alu_res = ~(src_a_i | src_b_i);
      4'b0111: alu_res = {{(DATA_W-1){1'b0}}, ($signed(src_a_i) < $signed(src_b_i))};
      default: alu_res = '0;
    endcase
  end

  // Step never exceeds the remaining count, so it always fits the shamt width.
  assign step_k  = (STEP_W'(cnt) > STEP_V) ? STEP_V[SHAMT_W-1:0] : cnt;
  assign shifted = dir ? (shreg >> step_k) : (shreg << step_k);

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    cnt_n       = cnt;
    dir_n       = dir;
    result_n    = result_o;
    out_valid_n = out_valid_o && !out_ready_i;
    load        = 1'b0;
    load_val    = '0;
`ifdef EX_FLAGS_EN
    load_ovf    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          if (fu_sel_i == 2'b01 && shamt_i != '0) begin
            shreg_n = src_b_i;
            dir_n   = left_right_i;
            cnt_n   = shamt_i;
            state_n = SHIFT;
          end else begin
            load = 1'b1;
            if (fu_sel_i == 2'b01) begin
              load_val = src_b_i;
            end else if (fu_sel_i == 2'b00) begin
              load_val = alu_res;
`ifdef EX_FLAGS_EN
              load_ovf = alu_ovf;
`endif
            end
          end
        end
      end
      SHIFT: begin
        if (can_load) begin
          shreg_n = shifted;
          cnt_n   = cnt - step_k;
          if (cnt == step_k) begin
            load     = 1'b1;
            load_val = shifted;
            state_n  = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      result_n    = load_val;
      out_valid_n = 1'b1;
    end
  end

`ifdef EX_FLAGS_EN
  always_comb begin
    zero_n = zero_o;
    ovf_n  = ovf_o;
    if (load) begin
      zero_n = (load_val == '0);
      ovf_n  = load_ovf;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      dir         <= 1'b0;
      result_o    <= '0;
      out_valid_o <= 1'b0;
`ifdef EX_FLAGS_EN
      zero_o      <= 1'b0;
      ovf_o       <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      cnt         <= cnt_n;
      dir         <= dir_n;
      result_o    <= result_n;
      out_valid_o <= out_valid_n;
`ifdef EX_FLAGS_EN
      zero_o      <= zero_n;
      ovf_o       <= ovf_n;
`endif
    end
  end

endmodule

// File: tb/tb_ex_shift_alu_unit.sv
// Directed bench for ex_shift_alu_unit: one-bit-step and eight-bit-step instances
// share stimulus; flag checks are compiled in with EX_FLAGS_EN.
module tb_ex_shift_alu_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic [3:0]  alu_op_i;
  logic [1:0]  fu_sel_i;
  logic        left_right_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic [4:0]  shamt_i;
  logic        out_ready_i;

  logic        in_ready_1, out_valid_1;
  logic [31:0] result_1;
  logic        in_ready_8, out_valid_8;
  logic [31:0] result_8;
`ifdef EX_FLAGS_EN
  logic        zero_1, ovf_1, zero_8, ovf_8;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  ex_shift_alu_unit #(.DATA_W(32), .SHIFT_STEP(1)) dut_step1 (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_1),
    .alu_op_i(alu_op_i), .fu_sel_i(fu_sel_i), .left_right_i(left_right_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .shamt_i(shamt_i),
    .out_valid_o(out_valid_1), .out_ready_i(out_ready_i), .result_o(result_1)
`ifdef EX_FLAGS_EN
    , .zero_o(zero_1), .ovf_o(ovf_1)
`endif
  );

  ex_shift_alu_unit #(.DATA_W(32), .SHIFT_STEP(8)) dut_step8 (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_8),
    .alu_op_i(alu_op_i), .fu_sel_i(fu_sel_i), .left_right_i(left_right_i),
    .src_a_i(src_a_i), .src_b_i(src_b_i), .shamt_i(shamt_i),
    .out_valid_o(out_valid_8), .out_ready_i(out_ready_i), .result_o(result_8)
`ifdef EX_FLAGS_EN
    , .zero_o(zero_8), .ovf_o(ovf_8)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic present(input logic [3:0] op, input logic [1:0] fu, input logic lr,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    in_valid_i   = 1'b1;
    alu_op_i     = op;
    fu_sel_i     = fu;
    left_right_i = lr;
    src_a_i      = a;
    src_b_i      = b;
    shamt_i      = sh;
    #1;
  endtask

  task automatic do_reset();
    rst_i      = 1'b1;
    in_valid_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
  endtask

  localparam int NV = 11;
  logic [3:0]  v_op  [NV] = '{4'b0111, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0010,
                              4'b0111, 4'b0011, 4'b0010, 4'b0010, 4'b0111};
  logic [1:0]  v_fu  [NV] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                              2'b00, 2'b00, 2'b10, 2'b11, 2'b00};
  logic [31:0] v_a   [NV] = '{32'hFFFF_FFFF, 32'h0, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
                              32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'h1, 32'h5, 32'h5, 32'h5,
                              32'h8000_0000};
  logic [31:0] v_b   [NV] = '{32'h1, 32'h1, 32'hFF00_FF00, 32'h0F0F_0F0F,
                              32'h00FF_00FF, 32'h2, 32'hFFFF_FFFF, 32'h6, 32'h6, 32'h6,
                              32'h7FFF_FFFF};
  logic [31:0] v_exp [NV] = '{32'h1, 32'hFFFF_FFFF, 32'hF000_F000, 32'hFFFF_FFFF,
                              32'hF000_F000, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1};

  initial begin
    logic seen_valid;
    out_ready_i  = 1'b1;
    alu_op_i     = '0;
    fu_sel_i     = '0;
    left_right_i = 1'b0;
    src_a_i      = '0;
    src_b_i      = '0;
    shamt_i      = '0;

    // reset state
    do_reset();
    check("rst_out_valid", out_valid_1, 0);
    check("rst_result", result_1, 0);
    check("rst_in_ready", in_ready_1, 1);

    // single add
    present(4'b0010, 2'b00, 1'b0, 32'd7, 32'd5, 5'd0);
    check("add_in_ready", in_ready_1, 1);
    step();
    in_valid_i = 1'b0;
    check("add_valid", out_valid_1, 1);
    check("add_result", result_1, 32'd12);

    // back-to-back ALU vectors, one per cycle
    for (int i = 0; i < NV; i++) begin
      present(v_op[i], v_fu[i], 1'b0, v_a[i], v_b[i], 5'd0);
      step();
      check($sformatf("vec%0d_valid", i), out_valid_1, 1);
      check($sformatf("vec%0d_result", i), result_1, v_exp[i]);
    end
    in_valid_i = 1'b0;
    step();
    check("vec_drain_valid", out_valid_1, 0);

    // serial left shift, one bit per cycle
    do_reset();
    present(4'b0000, 2'b01, 1'b0, 32'h0, 32'h1, 5'd4);
    step();
    in_valid_i = 1'b0;
    repeat (4) begin
      check("shl_busy_ready", in_ready_1, 0);
      check("shl_busy_valid", out_valid_1, 0);
      step();
    end
    check("shl_valid", out_valid_1, 1);
    check("shl_result", result_1, 32'h10);
    check("shl_ready_after", in_ready_1, 1);

    // zero shift amount passes src_b through in one cycle
    present(4'b0000, 2'b01, 1'b0, 32'h0, 32'h0000_ABCD, 5'd0);
    step();
    in_valid_i = 1'b0;
    check("sh0_valid", out_valid_1, 1);
    check("sh0_result", result_1, 32'h0000_ABCD);

    // right shift on the one-bit instance
    do_reset();
    present(4'b0000, 2'b01, 1'b1, 32'h0, 32'h0000_00F0, 5'd4);
    step();
    in_valid_i = 1'b0;
    repeat (4) step();
    check("shr1_valid", out_valid_1, 1);
    check("shr1_result", result_1, 32'h0000_000F);

    // eight-bit step: 31 positions in four shift cycles
    do_reset();
    present(4'b0000, 2'b01, 1'b1, 32'h0, 32'h8000_0000, 5'd31);
    step();
    in_valid_i = 1'b0;
    repeat (4) begin
      check("shr8_busy_valid", out_valid_8, 0);
      check("shr8_busy_ready", in_ready_8, 0);
      step();
    end
    check("shr8_valid", out_valid_8, 1);
    check("shr8_result", result_8, 32'h1);

    // downstream stall holds result and blocks the next op
    do_reset();
    present(4'b0010, 2'b00, 1'b0, 32'd7, 32'd5, 5'd0);
    step();
    out_ready_i = 1'b0;
    present(4'b0110, 2'b00, 1'b0, 32'd9, 32'd4, 5'd0);
    repeat (3) begin
      check("stall_valid", out_valid_1, 1);
      check("stall_result", result_1, 32'd12);
      check("stall_in_ready", in_ready_1, 0);
      step();
    end
    out_ready_i = 1'b1;
    #1;
    check("unstall_in_ready", in_ready_1, 1);
    step();
    in_valid_i = 1'b0;
    check("unstall_valid", out_valid_1, 1);
    check("unstall_result", result_1, 32'd5);
    step();
    check("unstall_drain", out_valid_1, 0);

    // reset during a shift discards it
    do_reset();
    present(4'b0000, 2'b01, 1'b0, 32'h0, 32'h3, 5'd10);
    step();
    in_valid_i = 1'b0;
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("abort_valid", out_valid_1, 0);
    check("abort_in_ready", in_ready_1, 1);
    seen_valid = 1'b0;
    repeat (12) begin
      step();
      if (out_valid_1) seen_valid = 1'b1;
    end
    check("abort_no_late_valid", seen_valid, 0);
    present(4'b0010, 2'b00, 1'b0, 32'd1, 32'd1, 5'd0);
    step();
    in_valid_i = 1'b0;
    check("abort_recover", result_1, 32'd2);

`ifdef EX_FLAGS_EN
    present(4'b0010, 2'b00, 1'b0, 32'h7FFF_FFFF, 32'h1, 5'd0);
    step();
    check("flag_add_ovf", ovf_1, 1);
    check("flag_add_zero", zero_1, 0);
    check("flag_add_result", result_1, 32'h8000_0000);
    present(4'b0110, 2'b00, 1'b0, 32'd5, 32'd5, 5'd0);
    step();
    check("flag_sub_ovf", ovf_1, 0);
    check("flag_sub_zero", zero_1, 1);
    present(4'b0110, 2'b00, 1'b0, 32'h8000_0000, 32'h1, 5'd0);
    step();
    check("flag_sub_wrap_ovf", ovf_1, 1);
    present(4'b0000, 2'b00, 1'b0, 32'h7FFF_FFFF, 32'h1, 5'd0);
    step();
    in_valid_i = 1'b0;
    check("flag_and_ovf", ovf_1, 0);
    check("flag_and_zero", zero_1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
